// File: rtl/bext_bdep_seq.sv
// Multi-cycle bit extract / bit deposit unit, BEAT_W mask bits per cycle.
// Define BEXT_BDEP_EARLY_TERM_EN to finish as soon as the remaining mask bits are all zero.
module bext_bdep_seq #(
    parameter int unsigned BEAT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [31:0] in_src,
    input  logic [31:0] in_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    localparam int unsigned NBEAT = 32 / BEAT_W;
    localparam int unsigned BCW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic              r_op;
    logic [31:0]       r_src;
    logic [31:0]       r_mask;
    logic [31:0]       r_result;
    logic [5:0]        r_offset;
    logic [BCW-1:0]    r_beat;

    logic [BEAT_W-1:0] w_mask_beat;
    logic [31:0]       w_beat_res;
    logic [5:0]        w_next_offset;
    logic              w_last_beat;
    logic              w_done_next;

    assign w_mask_beat = BEAT_W'(r_mask >> (32'(r_beat) * BEAT_W));
    assign w_last_beat = (r_beat == BCW'(NBEAT - 1));

    // Running count v_k starts at the offset carried in from earlier beats,
    // so each set mask bit sees the number of set bits below it.
    always_comb begin
        logic [5:0] v_k;
        logic [4:0] v_i;
        w_beat_res = r_result;
        v_k        = r_offset;
        v_i        = '0;
        for (int unsigned j = 0; j < BEAT_W; j++) begin
            v_i = 5'(32'(r_beat) * BEAT_W + j);
            if (w_mask_beat[j]) begin
                if (r_op)
                    w_beat_res[v_i] = r_src[v_k[4:0]];
                else
                    w_beat_res[v_k[4:0]] = r_src[v_i];
                v_k = v_k + 6'd1;
            end
        end
        w_next_offset = v_k;
    end

`ifdef BEXT_BDEP_EARLY_TERM_EN
    logic [31:0] w_mask_above;
    assign w_mask_above = r_mask >> ((32'(r_beat) + 32'd1) * BEAT_W);
    assign w_done_next  = w_last_beat | (w_mask_above == '0);
`else
    assign w_done_next  = w_last_beat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 1'b0;
            r_src    <= '0;
            r_mask   <= '0;
            r_result <= '0;
            r_offset <= '0;
            r_beat   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op     <= in_op;
                        r_src    <= in_src;
                        r_mask   <= in_mask;
                        r_result <= '0;
                        r_offset <= '0;
                        r_beat   <= '0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_result <= w_beat_res;
                    r_offset <= w_next_offset;
                    r_beat   <= r_beat + 1'b1;
                    if (w_done_next)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;

endmodule
